// File: rtl/alu_op_sequencer_pkg.sv
// Shared definitions for the ALU operation sequencer: FSM state encoding,
// opcode group codes, expected one-hot flag patterns and the divide opcode.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } seq_state_t;

  // Opcode group, taken from ALU_FUN[3:2]
  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_CMP   = 2'b10;
  localparam logic [1:0] GRP_SHIFT = 2'b11;

  // Expected flag vector per group, ordered {Arith, Logic, CMP, SHIFT}
  localparam logic [3:0] FLG_ARITH = 4'b1000;
  localparam logic [3:0] FLG_LOGIC = 4'b0100;
  localparam logic [3:0] FLG_CMP   = 4'b0010;
  localparam logic [3:0] FLG_SHIFT = 4'b0001;

  // Divide opcode; a zero divisor is rejected without touching the ALU
  localparam logic [3:0] FUN_DIV = 4'b0011;

  // Map an opcode group to the flag pattern the ALU must raise for it
  function automatic logic [3:0] grp_exp_flags(input logic [1:0] grp);
    logic [3:0] flg;
    case (grp)
      GRP_ARITH: flg = FLG_ARITH;
      GRP_LOGIC: flg = FLG_LOGIC;
      GRP_CMP:   flg = FLG_CMP;
      GRP_SHIFT: flg = FLG_SHIFT;
      default:   flg = FLG_ARITH;
    endcase
    return flg;
  endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command / response handshake bundle of the ALU operation sequencer.
// master = control/bus logic issuing commands, slave = the sequencer.
interface alu_op_sequencer_if #(
  parameter int ALU_WIDTH = 16
);
  logic                 CMD_VALID;
  logic                 CMD_READY;
  logic [ALU_WIDTH-1:0] CMD_A;
  logic [ALU_WIDTH-1:0] CMD_B;
  logic [3:0]           CMD_FUN;

  logic                 RSP_VALID;
  logic                 RSP_READY;
  logic [ALU_WIDTH-1:0] RSP_DATA;
  logic                 RSP_CARRY;
  logic                 RSP_ERR;
  logic [3:0]           RSP_FUN;

  modport master (
    output CMD_VALID, CMD_A, CMD_B, CMD_FUN, RSP_READY,
    input  CMD_READY, RSP_VALID, RSP_DATA, RSP_CARRY, RSP_ERR, RSP_FUN
  );

  modport slave (
    input  CMD_VALID, CMD_A, CMD_B, CMD_FUN, RSP_READY,
    output CMD_READY, RSP_VALID, RSP_DATA, RSP_CARRY, RSP_ERR, RSP_FUN
  );

endinterface

// File: rtl/alu_op_sequencer_result_mux.sv
// Result selection for the ALU sequencer: picks the result bus of the
// opcode group, gates the carry to the arithmetic group only and flags
// any deviation of the ALU flag vector from the group's one-hot pattern.
module alu_result_mux
  import alu_seq_pkg::*;
#(
  parameter int ALU_WIDTH = 16
) (
  input  logic [3:0]           i_fun,
  input  logic [ALU_WIDTH-1:0] i_arith,
  input  logic [ALU_WIDTH-1:0] i_logic,
  input  logic [ALU_WIDTH-1:0] i_cmp,
  input  logic [ALU_WIDTH-1:0] i_shift,
  input  logic                 i_carry,
  input  logic [3:0]           i_flags,
  output logic [ALU_WIDTH-1:0] o_data,
  output logic                 o_carry,
  output logic                 o_err
);

  logic [1:0] w_grp;
  assign w_grp = i_fun[3:2];

  // Group select, carry gating and flag compare
  always_comb begin
    o_data  = {ALU_WIDTH{1'b0}};
    o_carry = 1'b0;
    case (w_grp)
      GRP_ARITH: begin
        o_data  = i_arith;
        o_carry = i_carry;
      end
      GRP_LOGIC: o_data = i_logic;
      GRP_CMP:   o_data = i_cmp;
      GRP_SHIFT: o_data = i_shift;
      default:   o_data = {ALU_WIDTH{1'b0}};
    endcase
    o_err = (i_flags != grp_exp_flags(w_grp));
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// ALU operation sequencer: accepts one command at a time, drives the ALU
// operands, waits out the ALU latency, then returns the group-selected
// result with carry and a flag-consistency error bit.
// Optional build macro ALU_SEQ_STATS_EN adds saturating STAT_OPS/STAT_ERRS
// response counters.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int ALU_WIDTH = 16,
  parameter int LATENCY   = 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  alu_op_sequencer_if.slave    bus,
  output logic [ALU_WIDTH-1:0] ALU_A,
  output logic [ALU_WIDTH-1:0] ALU_B,
  output logic [3:0]           ALU_FUN,
  input  logic [ALU_WIDTH-1:0] Arith_OUT,
  input  logic [ALU_WIDTH-1:0] Logic_OUT,
  input  logic [ALU_WIDTH-1:0] CMP_OUT,
  input  logic [ALU_WIDTH-1:0] SHIFT_OUT,
  input  logic                 Carry_OUT,
  input  logic                 Arith_Flag,
  input  logic                 Logic_Flag,
  input  logic                 CMP_Flag,
  input  logic                 SHIFT_Flag
`ifdef ALU_SEQ_STATS_EN
  ,
  output logic [15:0]          STAT_OPS,
  output logic [15:0]          STAT_ERRS
`endif
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAT_C = CW'(LATENCY);

  seq_state_t           r_state;
  logic [CW-1:0]        r_cnt;
  logic [ALU_WIDTH-1:0] w_data;
  logic                 w_carry;
  logic                 w_err;
  logic [3:0]           w_flags;
  logic                 w_div0;

  assign w_flags = {Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag};
  assign w_div0  = (bus.CMD_FUN == FUN_DIV) && (bus.CMD_B == {ALU_WIDTH{1'b0}});

  // Ready depends only on state and reset, never on CMD_VALID
  assign bus.CMD_READY = (r_state == IDLE) & ~RST;

  alu_result_mux #(
    .ALU_WIDTH (ALU_WIDTH)
  ) u_result_mux (
    .i_fun   (ALU_FUN),
    .i_arith (Arith_OUT),
    .i_logic (Logic_OUT),
    .i_cmp   (CMP_OUT),
    .i_shift (SHIFT_OUT),
    .i_carry (Carry_OUT),
    .i_flags (w_flags),
    .o_data  (w_data),
    .o_carry (w_carry),
    .o_err   (w_err)
  );

  // Sequencer FSM with registered ALU drive and response outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state       <= IDLE;
      r_cnt         <= {CW{1'b0}};
      ALU_A         <= {ALU_WIDTH{1'b0}};
      ALU_B         <= {ALU_WIDTH{1'b0}};
      ALU_FUN       <= 4'b0000;
      bus.RSP_VALID <= 1'b0;
      bus.RSP_DATA  <= {ALU_WIDTH{1'b0}};
      bus.RSP_CARRY <= 1'b0;
      bus.RSP_ERR   <= 1'b0;
      bus.RSP_FUN   <= 4'b0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.CMD_VALID) begin
            bus.RSP_FUN <= bus.CMD_FUN;
            if (w_div0) begin
              // Rejected divide-by-zero: answer at once, ALU left untouched
              bus.RSP_VALID <= 1'b1;
              bus.RSP_DATA  <= {ALU_WIDTH{1'b0}};
              bus.RSP_CARRY <= 1'b0;
              bus.RSP_ERR   <= 1'b1;
              r_state       <= RESP;
            end else begin
              ALU_A   <= bus.CMD_A;
              ALU_B   <= bus.CMD_B;
              ALU_FUN <= bus.CMD_FUN;
              r_cnt   <= LAT_C;
              r_state <= WAIT;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          if (r_cnt != {CW{1'b0}}) begin
            r_cnt <= r_cnt - CW'(1);
          end else begin
            bus.RSP_VALID <= 1'b1;
            bus.RSP_DATA  <= w_data;
            bus.RSP_CARRY <= w_carry;
            bus.RSP_ERR   <= w_err;
            r_state       <= RESP;
          end
        end
        RESP: begin
          if (bus.RSP_READY) begin
            bus.RSP_VALID <= 1'b0;
            r_state       <= IDLE;
          end else begin
            r_state <= RESP;
          end
        end
        default: begin
          bus.RSP_VALID <= 1'b0;
          r_state       <= IDLE;
        end
      endcase
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic w_rsp_hs;
  assign w_rsp_hs = (r_state == RESP) && bus.RSP_VALID && bus.RSP_READY;

  // Saturating counters of completed responses and of errored responses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      STAT_OPS  <= 16'h0000;
      STAT_ERRS <= 16'h0000;
    end else if (w_rsp_hs) begin
      if (STAT_OPS != 16'hFFFF) begin
        STAT_OPS <= STAT_OPS + 16'h0001;
      end
      if (bus.RSP_ERR && (STAT_ERRS != 16'hFFFF)) begin
        STAT_ERRS <= STAT_ERRS + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Command-side initiator for ALU_TOP. It accepts one operation at a time over a valid/ready command interface and drives A/B/ALU_FUN into the ALU. It waits out the ALU's registered latency, then selects the result bus matching the opcode group and checks the one-hot flag vector. The result is returned over a valid/ready response interface. It sits between the control/bus logic and ALU_TOP.

Parameters:
ALU_WIDTH, 16, operand/result width; must match ALU_TOP ALU_WIDTH
LATENCY, 1, ALU clock edges from stable inputs to valid outputs (≥1)

Ports:
CLK  in  1  single clock, rising edge
RST  in  1  reset, asynchronous, active-high
CMD_VALID  in  1  command present
CMD_READY  out  1  sequencer can accept a command
CMD_A  in  ALU_WIDTH  operand A
CMD_B  in  ALU_WIDTH  operand B
CMD_FUN  in  4  ALU function code
ALU_A  out  ALU_WIDTH  to ALU_TOP.A
ALU_B  out  ALU_WIDTH  to ALU_TOP.B
ALU_FUN  out  4  to ALU_TOP.ALU_FUN
Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT  in  ALU_WIDTH each  ALU result buses
Carry_OUT  in  1  ALU carry
Arith_Flag, Logic_Flag, CMP_Flag, SHIFT_Flag  in  1 each  ALU unit-valid flags
RSP_VALID  out  1  response present
RSP_READY  in  1  consumer accepts response
RSP_DATA  out  ALU_WIDTH  selected result
RSP_CARRY  out  1  Carry_OUT for arith group, else 0
RSP_ERR  out  1  flag mismatch or rejected divide-by-zero
RSP_FUN  out  4  echo of function code

Behaviour:
- FSM states: IDLE, WAIT, RESP.
- Reset (async, any state): state=IDLE; ALU_A=0, ALU_B=0, ALU_FUN=0; RSP_VALID=0, RSP_DATA=0, RSP_CARRY=0, RSP_ERR=0, RSP_FUN=0; wait counter=0.
- CMD_READY = (state==IDLE) & ~RST, combinational. There is no combinational path from CMD_VALID to CMD_READY.
- IDLE, handshake at edge E0 with normal command: register CMD_A/B/FUN into ALU_A/B/FUN and RSP_FUN; counter=LATENCY; go to WAIT.
- IDLE, handshake with CMD_FUN==4'b0011 and CMD_B==0: ALU_* outputs are not updated. Go directly to RESP at E0 with RSP_VALID=1, RSP_DATA=0, RSP_ERR=1, RSP_CARRY=0.
- WAIT: each edge, if counter≠0, decrement. If counter==0, capture the result and go to RESP. Capture occurs at edge E0+LATENCY+1, so RSP_VALID is high after E0+2 when LATENCY=1.
- Group select by ALU_FUN[3:2]:
  - 00: Arith_OUT, expected flags 1000
  - 01: Logic_OUT, expected 0100
  - 10: CMP_OUT, expected 0010
  - 11: SHIFT_OUT, expected 0001
- Flag vector order is {Arith,Logic,CMP,SHIFT}. RSP_ERR = (flags ≠ expected) at the capture edge.
- RSP_DATA and RSP_CARRY are captured regardless of RSP_ERR.
- RESP: all RSP_* outputs hold stable while RSP_READY=0. On RSP_VALID&RSP_READY the sequencer returns to IDLE and clears RSP_VALID. RSP_DATA/ERR/CARRY/FUN retain their last values.
- ALU_A/B/FUN hold the last issued command until the next accepted non-rejected command.
- Throughput: one command per LATENCY+3 cycles minimum. No overlap, no queuing. CMD_VALID outside IDLE is ignored, and the command must be held by the source.
- RST asserted mid-WAIT or mid-RESP aborts the operation; no response is ever produced for it.

Optional Feature:
ALU_SEQ_STATS_EN:
- When defined, adds outputs STAT_OPS[15:0] and STAT_ERRS[15:0].
- STAT_OPS increments on each response handshake. STAT_ERRS increments on each response handshake with RSP_ERR=1.
- Both counters saturate at 16'hFFFF and reset to 0.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package alu_seq_pkg holds:
  - state encoding (IDLE/WAIT/RESP)
  - group codes GRP_ARITH=2'b00, GRP_LOGIC=2'b01, GRP_CMP=2'b10, GRP_SHIFT=2'b11
  - expected-flag constants per group
  - FUN_DIV=4'b0011
- Sub-module alu_result_mux: combinational group select, carry gating and flag-mismatch compare. It is instantiated once by the sequencer.

Test Plan:
1. ADD: CMD A=10, B=5, FUN=0000 accepted at E0 with real ALU_TOP -> ALU_FUN=0000 after E0; RSP_VALID after E0+2; RSP_DATA=15, RSP_CARRY=0, RSP_ERR=0.
2. ADD with carry: A=32780, B=32770, FUN=0000 -> RSP_DATA=14, RSP_CARRY=1, RSP_ERR=0.
3. Divide-by-zero: A=10, B=0, FUN=0011 -> ALU_* unchanged from the previous op; RSP_VALID after E0; RSP_DATA=0, RSP_ERR=1. Then A=10, B=5, FUN=0011 -> RSP_DATA=2, RSP_ERR=0.
4. Backpressure: NOR A=9, B=3, FUN=0111 with RSP_READY=0 for 5 cycles -> RSP_DATA=16'hFFF4 stable; CMD_READY=0; a second CMD_VALID is not accepted. After RSP_READY=1, CMD_READY=1 next cycle.
5. Flag fault: stub ALU drives flags 0100 for CMP_GR A=10, B=5, FUN=1010 with CMP_OUT=2 -> RSP_DATA=2, RSP_ERR=1. With flags 0010 -> RSP_ERR=0.
6. Reset mid-WAIT: assert RST one cycle after acceptance -> all outputs 0 immediately; no RSP_VALID after release; CMD_READY=1 once RST=0. STAT_OPS=0 when ALU_SEQ_STATS_EN is defined.
